// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the two requester ports (A = CPU MEM stage,
//               B = loader/debug) and the data-memory side of dmem_arbiter.
//               slave  : seen from the arbiter
//               master : seen from the requesters/memory model
// Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;
    // requester A
    logic        a_req_i;
    logic        a_we_i;
    logic [31:0] a_addr_i;
    logic [31:0] a_wdata_i;
    logic        a_gnt_o;
    logic        a_done_o;
    logic        a_err_o;
    logic [31:0] a_rdata_o;
    // requester B
    logic        b_req_i;
    logic        b_we_i;
    logic [31:0] b_addr_i;
    logic [31:0] b_wdata_i;
    logic        b_gnt_o;
    logic        b_done_o;
    logic        b_err_o;
    logic [31:0] b_rdata_o;
    // data memory
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [2:0]  mem_signal_o;
    logic [31:0] mem_data_i;

    modport slave (
        input  a_req_i, a_we_i, a_addr_i, a_wdata_i,
        input  b_req_i, b_we_i, b_addr_i, b_wdata_i,
        input  mem_data_i,
        output a_gnt_o, a_done_o, a_err_o, a_rdata_o,
        output b_gnt_o, b_done_o, b_err_o, b_rdata_o,
        output mem_addr_o, mem_data_o, mem_signal_o
    );

    modport master (
        output a_req_i, a_we_i, a_addr_i, a_wdata_i,
        output b_req_i, b_we_i, b_addr_i, b_wdata_i,
        output mem_data_i,
        input  a_gnt_o, a_done_o, a_err_o, a_rdata_o,
        input  b_gnt_o, b_done_o, b_err_o, b_rdata_o,
        input  mem_addr_o, mem_data_o, mem_signal_o
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Two-port arbiter/sequencer for the byte-addressable data
//               memory. One access at a time: IDLE -> ISSUE -> DONE -> IDLE.
// Ports       : clk_i    - clock, rising edge
//               rst_n_i  - asynchronous active-low reset
//               bus      - dmem_arbiter_if.slave (requesters A/B + memory)
// Parameters  : DEPTH_BYTES - memory size in bytes (last legal word at -4)
//               FIXED_PRIO  - 0 round-robin, 1 port A wins ties
// Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
    parameter int unsigned DEPTH_BYTES = 32,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dmem_arbiter_if.slave  bus
);

    localparam logic [31:0] MAX_ADDR = 32'(DEPTH_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        sel_b;     // granted port of the access in flight
    logic        last_b;    // round-robin pointer: last grant went to B
    logic        err_q;     // latched range-check result

    logic        any_req;
    logic        pick_b;
    logic        pick_we;
    logic        pick_err;
    logic [31:0] pick_addr;
    logic [31:0] pick_wdata;

    // Winner selection and next state
    always_comb begin
        state_nxt  = state;
        any_req    = bus.a_req_i | bus.b_req_i;
        // B wins when alone, or on a tie under round-robin when A went last
        pick_b     = bus.b_req_i & (~bus.a_req_i | (~FIXED_PRIO & ~last_b));
        pick_we    = pick_b ? bus.b_we_i    : bus.a_we_i;
        pick_addr  = pick_b ? bus.b_addr_i  : bus.a_addr_i;
        pick_wdata = pick_b ? bus.b_wdata_i : bus.a_wdata_i;
        pick_err   = (pick_addr > MAX_ADDR);

        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state <= IDLE;
        else          state <= state_nxt;
    end

    // Registered outputs and latched request fields
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_b            <= 1'b0;
            last_b           <= 1'b1;   // makes A win the first tie
            err_q            <= 1'b0;
            bus.a_gnt_o      <= 1'b0;
            bus.b_gnt_o      <= 1'b0;
            bus.a_done_o     <= 1'b0;
            bus.b_done_o     <= 1'b0;
            bus.a_err_o      <= 1'b0;
            bus.b_err_o      <= 1'b0;
            bus.a_rdata_o    <= 32'h0;
            bus.b_rdata_o    <= 32'h0;
            bus.mem_addr_o   <= 32'h0;
            bus.mem_data_o   <= 32'h0;
            bus.mem_signal_o <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        sel_b            <= pick_b;
                        last_b           <= pick_b;
                        err_q            <= pick_err;
                        bus.a_gnt_o      <= ~pick_b;
                        bus.b_gnt_o      <= pick_b;
                        bus.mem_addr_o   <= pick_addr;
                        bus.mem_data_o   <= pick_wdata;
                        // an out-of-range access never touches the memory
                        bus.mem_signal_o <= pick_err ? 3'b000
                                          : (pick_we ? 3'b001 : 3'b010);
                    end
                end
                ISSUE: begin
                    bus.a_gnt_o      <= 1'b0;
                    bus.b_gnt_o      <= 1'b0;
                    bus.mem_signal_o <= 3'b000;
                    bus.a_done_o     <= ~sel_b;
                    bus.b_done_o     <= sel_b;
                    bus.a_err_o      <= ~sel_b & err_q;
                    bus.b_err_o      <= sel_b & err_q;
                    // read enable is only set for a legal read, so this
                    // also gives 0 on writes and errors
                    bus.a_rdata_o    <= (~sel_b & bus.mem_signal_o[1]) ? bus.mem_data_i : 32'h0;
                    bus.b_rdata_o    <= ( sel_b & bus.mem_signal_o[1]) ? bus.mem_data_i : 32'h0;
                end
                DONE: begin
                    bus.a_done_o  <= 1'b0;
                    bus.b_done_o  <= 1'b0;
                    bus.a_err_o   <= 1'b0;
                    bus.b_err_o   <= 1'b0;
                    bus.a_rdata_o <= 32'h0;
                    bus.b_rdata_o <= 32'h0;
                end
                default: begin
                    bus.a_gnt_o      <= 1'b0;
                    bus.b_gnt_o      <= 1'b0;
                    bus.a_done_o     <= 1'b0;
                    bus.b_done_o     <= 1'b0;
                    bus.a_err_o      <= 1'b0;
                    bus.b_err_o      <= 1'b0;
                    bus.a_rdata_o    <= 32'h0;
                    bus.b_rdata_o    <= 32'h0;
                    bus.mem_signal_o <= 3'b000;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed bench for dmem_arbiter. A round-robin instance is
//               backed by a little-endian byte memory model; a fixed-priority
//               instance checks tie-breaking only.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter_if ifc ();
    dmem_arbiter_if ifc_fp ();

    dmem_arbiter #(.DEPTH_BYTES(32), .FIXED_PRIO(1'b0)) u_rr (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc)
    );

    dmem_arbiter #(.DEPTH_BYTES(32), .FIXED_PRIO(1'b1)) u_fp (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (ifc_fp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: byte i initialised to 0xA0+i
    logic [7:0] mem [0:31];

    always @(posedge clk) begin
        if (ifc.mem_signal_o[0]) begin
            for (int k = 0; k < 4; k++)
                mem[(int'(ifc.mem_addr_o[4:0]) + k) & 31] <= ifc.mem_data_o[8*k +: 8];
        end
    end

    always @(negedge clk) begin
        if (ifc.mem_signal_o[1]) begin
            ifc.mem_data_i <= {mem[(int'(ifc.mem_addr_o[4:0]) + 3) & 31],
                               mem[(int'(ifc.mem_addr_o[4:0]) + 2) & 31],
                               mem[(int'(ifc.mem_addr_o[4:0]) + 1) & 31],
                               mem[ int'(ifc.mem_addr_o[4:0])      & 31]};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One complete access on the round-robin instance, other port idle
    task automatic access(input string tag, input bit port_b, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input bit exp_err);
        @(negedge clk);
        if (port_b) begin
            ifc.b_req_i = 1'b1; ifc.b_we_i = we; ifc.b_addr_i = addr; ifc.b_wdata_i = wdata;
        end else begin
            ifc.a_req_i = 1'b1; ifc.a_we_i = we; ifc.a_addr_i = addr; ifc.a_wdata_i = wdata;
        end
        @(posedge clk); #1;
        check({tag, " gnt"}, {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, port_b ? 32'd2 : 32'd1);
        check({tag, " sig"}, {29'd0, ifc.mem_signal_o},
              exp_err ? 32'd0 : (we ? 32'd1 : 32'd2));
        check({tag, " addr"}, ifc.mem_addr_o, addr);
        @(negedge clk);
        ifc.a_req_i = 1'b0;
        ifc.b_req_i = 1'b0;
        @(posedge clk); #1;
        check({tag, " done"}, {30'd0, ifc.b_done_o, ifc.a_done_o}, port_b ? 32'd2 : 32'd1);
        check({tag, " err"},  {30'd0, ifc.b_err_o, ifc.a_err_o},
              exp_err ? (port_b ? 32'd2 : 32'd1) : 32'd0);
        check({tag, " rdata"}, port_b ? ifc.b_rdata_o : ifc.a_rdata_o, exp_rdata);
        check({tag, " other rdata"}, port_b ? ifc.a_rdata_o : ifc.b_rdata_o, 32'h0);
        check({tag, " sig done"}, {29'd0, ifc.mem_signal_o}, 32'd0);
        @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'(8'hA0 + i);
        rst_n = 1'b0;
        ifc.a_req_i = 0; ifc.a_we_i = 0; ifc.a_addr_i = 0; ifc.a_wdata_i = 0;
        ifc.b_req_i = 0; ifc.b_we_i = 0; ifc.b_addr_i = 0; ifc.b_wdata_i = 0;
        ifc.mem_data_i = 0;
        ifc_fp.a_req_i = 0; ifc_fp.a_we_i = 0; ifc_fp.a_addr_i = 0; ifc_fp.a_wdata_i = 0;
        ifc_fp.b_req_i = 0; ifc_fp.b_we_i = 0; ifc_fp.b_addr_i = 0; ifc_fp.b_wdata_i = 0;
        ifc_fp.mem_data_i = 0;

        // ---- reset state
        #1;
        check("rst gnt",   {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, 32'd0);
        check("rst done",  {30'd0, ifc.b_done_o, ifc.a_done_o}, 32'd0);
        check("rst err",   {30'd0, ifc.b_err_o, ifc.a_err_o}, 32'd0);
        check("rst sig",   {29'd0, ifc.mem_signal_o}, 32'd0);
        check("rst maddr", ifc.mem_addr_o, 32'd0);
        check("rst rdata", ifc.a_rdata_o | ifc.b_rdata_o, 32'd0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // ---- single-port accesses
        access("A wr 8",     1'b0, 1'b1, 32'd8,  32'hDEADBEEF, 32'h0,        1'b0);
        access("A rd 8",     1'b0, 1'b0, 32'd8,  32'h0,        32'hDEADBEEF, 1'b0);
        access("A rd top",   1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,  32'h0,        1'b1);
        access("B rd 28",    1'b1, 1'b0, 32'd28, 32'h0,        32'hBFBEBDBC, 1'b0);
        access("B rd 29",    1'b1, 1'b0, 32'd29, 32'h0,        32'h0,        1'b1);

        // ---- round-robin tie, held through 4 accesses (last grant was B)
        @(negedge clk);
        ifc.a_req_i = 1'b1; ifc.a_we_i = 1'b0; ifc.a_addr_i = 32'd0;
        ifc.b_req_i = 1'b1; ifc.b_we_i = 1'b0; ifc.b_addr_i = 32'd16;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr gnt %0d", i), {30'd0, ifc.b_gnt_o, ifc.a_gnt_o},
                  (i % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            check($sformatf("rr done %0d", i), {30'd0, ifc.b_done_o, ifc.a_done_o},
                  (i % 2 == 1) ? 32'd2 : 32'd1);
            check($sformatf("rr rdata %0d", i), (i % 2 == 1) ? ifc.b_rdata_o : ifc.a_rdata_o,
                  (i % 2 == 1) ? 32'hB3B2B1B0 : 32'hA3A2A1A0);
            if (i == 3) begin
                @(negedge clk);
                ifc.a_req_i = 1'b0;
                ifc.b_req_i = 1'b0;
            end
            @(posedge clk);
        end

        // ---- fixed priority: A wins while it holds req, then B
        @(negedge clk);
        ifc_fp.a_req_i = 1'b1;
        ifc_fp.b_req_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("fp gnt %0d", i), {30'd0, ifc_fp.b_gnt_o, ifc_fp.a_gnt_o}, 32'd1);
            @(posedge clk); #1;
            check($sformatf("fp done %0d", i), {30'd0, ifc_fp.b_done_o, ifc_fp.a_done_o}, 32'd1);
            if (i == 2) begin
                @(negedge clk);
                ifc_fp.a_req_i = 1'b0;
            end
            @(posedge clk);
        end
        @(posedge clk); #1;
        check("fp gnt B", {30'd0, ifc_fp.b_gnt_o, ifc_fp.a_gnt_o}, 32'd2);
        @(negedge clk); ifc_fp.b_req_i = 1'b0;
        @(posedge clk); #1;
        check("fp done B", {30'd0, ifc_fp.b_done_o, ifc_fp.a_done_o}, 32'd2);
        @(posedge clk);

        // ---- reset in the middle of an ISSUE write
        @(negedge clk);
        ifc.a_req_i = 1'b1; ifc.a_we_i = 1'b1; ifc.a_addr_i = 32'd12; ifc.a_wdata_i = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("mid gnt", {31'd0, ifc.a_gnt_o}, 32'd1);
        check("mid sig", {29'd0, ifc.mem_signal_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async sig",   {29'd0, ifc.mem_signal_o}, 32'd0);
        check("async gnt",   {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, 32'd0);
        check("async maddr", ifc.mem_addr_o, 32'd0);
        check("async mdata", ifc.mem_data_o, 32'd0);
        ifc.a_req_i = 1'b0;
        @(posedge clk); #1;
        check("rst no done", {30'd0, ifc.b_done_o, ifc.a_done_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.a_req_i = 1'b1; ifc.a_we_i = 1'b0; ifc.a_addr_i = 32'd0;
        ifc.b_req_i = 1'b1; ifc.b_we_i = 1'b0; ifc.b_addr_i = 32'd0;
        @(posedge clk); #1;
        check("post-rst tie", {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, 32'd1);
        @(negedge clk);
        ifc.a_req_i = 1'b0;
        ifc.b_req_i = 1'b0;
        @(posedge clk); #1;
        check("post-rst done", {30'd0, ifc.b_done_o, ifc.a_done_o}, 32'd1);
        @(posedge clk);

        // ---- B writes while A waits, then A reads the new word
        @(negedge clk);
        ifc.b_req_i = 1'b1; ifc.b_we_i = 1'b1; ifc.b_addr_i = 32'd4; ifc.b_wdata_i = 32'h12345678;
        ifc.a_req_i = 1'b1; ifc.a_we_i = 1'b0; ifc.a_addr_i = 32'd4;
        @(posedge clk); #1;
        check("bw gnt", {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, 32'd2);
        check("bw sig", {29'd0, ifc.mem_signal_o}, 32'd1);
        @(negedge clk); ifc.b_req_i = 1'b0;
        @(posedge clk); #1;
        check("bw done", {30'd0, ifc.b_done_o, ifc.a_done_o}, 32'd2);
        @(posedge clk);
        @(posedge clk); #1;
        check("ar gnt", {30'd0, ifc.b_gnt_o, ifc.a_gnt_o}, 32'd1);
        check("ar sig", {29'd0, ifc.mem_signal_o}, 32'd2);
        @(negedge clk); ifc.a_req_i = 1'b0;
        @(posedge clk); #1;
        check("ar done",  {30'd0, ifc.b_done_o, ifc.a_done_o}, 32'd1);
        check("ar rdata", ifc.a_rdata_o, 32'h12345678);
        check("ar err",   {31'd0, ifc.a_err_o}, 32'd0);
        @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
